// File: rtl/regfile_pool_pkg.sv
// Shared register-map offsets and engine FSM states for the shadowed config register pool.
package regfile_pool_pkg;

    localparam int OFF_W = 6;

    localparam logic [OFF_W-1:0] OFF_CTRL      = 6'h00;
    localparam logic [OFF_W-1:0] OFF_CFG_BASE  = 6'h01;
    localparam logic [OFF_W-1:0] OFF_STATUS    = 6'h10;
    localparam logic [OFF_W-1:0] OFF_STAT_BASE = 6'h11;
    localparam logic [OFF_W-1:0] OFF_ACT_BASE  = 6'h20;
    localparam logic [OFF_W-1:0] OFF_IRQ_EN    = 6'h30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN
    } state_t;

endpackage

// File: rtl/regfile_pool_shadow_sticky_w1c.sv
// Sticky status bit: hardware set, software write-1-to-clear; set wins on collision.
module sticky_w1c (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else if (clr) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_pool_shadow.sv
// Config register pool with shadow/active copies, engine launch FSM, sticky status and IRQ.
module regfile_pool_shadow
    import regfile_pool_pkg::*;
#(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 14,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = 'h200,
    parameter int                 N_CFG     = 8,
    parameter int                 N_STAT    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic [DATA_W-1:0]        read_data,
    output logic                     rd_valid,
    output logic [N_CFG*DATA_W-1:0]  cfg_active,
    input  logic [N_STAT*DATA_W-1:0] stat_in,
    output logic                     start_pulse,
    input  logic                     engine_done,
    output logic                     irq
);

    state_t             state;
    logic [DATA_W-1:0]  shadow [N_CFG];
    logic [DATA_W-1:0]  active [N_CFG];
    logic               irq_en;
    logic               done_q;
    logic               err_q;

    logic [ADDR_W-1:0]  rel;
    logic [OFF_W-1:0]   off;
    logic               in_blk;
    logic               wr_hit;
    logic               start_req;
    logic               busy;
    logic               launch;
    logic [DATA_W-1:0]  rd_mux;

    // The block spans 64 offsets above BASE_ADDR; anything else decodes as unmapped.
    assign rel       = addr - BASE_ADDR;
    assign in_blk    = (addr >= BASE_ADDR) && (rel[ADDR_W-1:OFF_W] == '0);
    assign off       = rel[OFF_W-1:0];
    assign wr_hit    = wr_en && in_blk;
    assign start_req = wr_hit && (off == OFF_CTRL) && write_data[0];
    assign busy      = (state != ST_IDLE);
    assign launch    = start_req && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            start_pulse <= 1'b0;
        end else begin
            start_pulse <= launch;
            case (state)
                ST_IDLE:   if (launch) state <= ST_LAUNCH;
                ST_LAUNCH: state <= ST_RUN;
                ST_RUN:    if (engine_done) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CFG; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            irq_en <= 1'b0;
        end else begin
            // Copy takes the pre-write shadow image if a shadow write lands on the launch cycle.
            if (launch) begin
                for (int k = 0; k < N_CFG; k++) active[k] <= shadow[k];
            end
            for (int k = 0; k < N_CFG; k++) begin
                if (wr_hit && (off == OFF_CFG_BASE + OFF_W'(k))) shadow[k] <= write_data;
            end
            if (wr_hit && (off == OFF_IRQ_EN)) irq_en <= write_data[0];
        end
    end

    sticky_w1c u_done (
        .clk (clk),
        .rst (rst),
        .set (state == ST_RUN && engine_done),
        .clr (wr_hit && (off == OFF_STATUS) && write_data[1]),
        .q   (done_q)
    );

    sticky_w1c u_err (
        .clk (clk),
        .rst (rst),
        .set (start_req && busy),
        .clr (wr_hit && (off == OFF_STATUS) && write_data[2]),
        .q   (err_q)
    );

    always_comb begin
        rd_mux = '0;
        if (in_blk) begin
            if (off == OFF_STATUS) rd_mux[2:0] = {err_q, done_q, busy};
            if (off == OFF_IRQ_EN) rd_mux[0] = irq_en;
            for (int k = 0; k < N_CFG; k++) begin
                if (off == OFF_CFG_BASE + OFF_W'(k)) rd_mux = shadow[k];
                if (off == OFF_ACT_BASE + OFF_W'(k)) rd_mux = active[k];
            end
            for (int k = 0; k < N_STAT; k++) begin
                if (off == OFF_STAT_BASE + OFF_W'(k)) rd_mux = stat_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Read stage: decoded value captured one cycle after rd_en, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) read_data <= rd_mux;
        end
    end

    for (genvar g = 0; g < N_CFG; g++) begin : g_act
        assign cfg_active[g*DATA_W +: DATA_W] = active[g];
    end

    assign irq = done_q & irq_en;

endmodule

// File: tb/tb_regfile_pool_shadow.sv
// Scoreboard bench for regfile_pool_shadow: reads queue expectations, monitor pops them on rd_valid.
module tb_regfile_pool_shadow;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic         rd_en;
    logic [13:0]  addr;
    logic [15:0]  write_data;
    logic [15:0]  read_data;
    logic         rd_valid;
    logic [127:0] cfg_active;
    logic [47:0]  stat_in;
    logic         start_pulse;
    logic         engine_done;
    logic         irq;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [15:0]  exp_q [$];
    logic         want_vld;
    logic [15:0]  exp_rd;

    always #5 clk = ~clk;

    regfile_pool_shadow dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .write_data  (write_data),
        .read_data   (read_data),
        .rd_valid    (rd_valid),
        .cfg_active  (cfg_active),
        .stat_in     (stat_in),
        .start_pulse (start_pulse),
        .engine_done (engine_done),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; addr = a; write_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a, input logic [15:0] e);
        @(negedge clk);
        rd_en = 1'b1; addr = a;
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        engine_done = 1'b1;
        @(negedge clk);
        engine_done = 1'b0;
    endtask

    // Monitor: rd_valid must track last cycle's rd_en; data compared against scoreboard head.
    initial begin
        forever begin
            @(posedge clk);
            want_vld = rd_en && !rst;
            #1;
            check("rd_valid", {31'b0, rd_valid}, {31'b0, want_vld});
            if (rd_valid && exp_q.size() != 0) begin
                exp_rd = exp_q.pop_front();
                check("read_data", {16'b0, read_data}, {16'b0, exp_rd});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; write_data = '0;
        stat_in = '0; engine_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_start_pulse", {31'b0, start_pulse}, 0);
        check("rst_irq", {31'b0, irq}, 0);
        check("rst_cfg_active", cfg_active[31:0] | cfg_active[127:96], 0);

        // Every mapped offset reads zero out of reset.
        rd(14'h200, 16'h0);
        for (int k = 1; k <= 8; k++) rd(14'h200 + 14'(k), 16'h0);
        for (int k = 0; k <= 3; k++) rd(14'h210 + 14'(k), 16'h0);
        for (int k = 0; k < 8; k++) rd(14'h220 + 14'(k), 16'h0);
        rd(14'h230, 16'h0);

        // Shadow write leaves active untouched until a launch.
        wr(14'h201, 16'h0040);
        rd(14'h220, 16'h0000);
        rd(14'h201, 16'h0040);
        wr(14'h200, 16'h0001);
        check("launch_pulse", {31'b0, start_pulse}, 1);
        check("launch_cfg0", {16'b0, cfg_active[15:0]}, 32'h0040);
        @(negedge clk);
        check("run_pulse_low", {31'b0, start_pulse}, 0);
        rd(14'h210, 16'h0001);

        // Start while busy: ignored, err set, shadow still writable.
        wr(14'h201, 16'h0080);
        wr(14'h200, 16'h0001);
        check("busy_no_pulse", {31'b0, start_pulse}, 0);
        check("busy_cfg0", {16'b0, cfg_active[15:0]}, 32'h0040);
        rd(14'h210, 16'h0005);
        rd(14'h201, 16'h0080);
        rd(14'h220, 16'h0040);

        // Completion raises done and irq; W1C of done drops irq.
        wr(14'h230, 16'h0001);
        rd(14'h230, 16'h0001);
        check("irq_before_done", {31'b0, irq}, 0);
        pulse_done();
        rd(14'h210, 16'h0006);
        check("irq_after_done", {31'b0, irq}, 1);
        wr(14'h210, 16'h0002);
        check("irq_after_clr", {31'b0, irq}, 0);
        rd(14'h210, 16'h0004);

        // Relaunch, then engine_done collides with a W1C of done: set wins.
        wr(14'h200, 16'h0001);
        check("relaunch_pulse", {31'b0, start_pulse}, 1);
        check("relaunch_cfg0", {16'b0, cfg_active[15:0]}, 32'h0080);
        @(negedge clk);
        engine_done = 1'b1; wr_en = 1'b1; addr = 14'h210; write_data = 16'h0002;
        @(negedge clk);
        engine_done = 1'b0; wr_en = 1'b0;
        rd(14'h210, 16'h0006);
        check("irq_collide", {31'b0, irq}, 1);
        wr(14'h210, 16'h0006);
        pulse_done();
        rd(14'h210, 16'h0000);

        // Status inputs are read-only; out-of-block and unused offsets read zero.
        stat_in = {16'h0003, 16'h0002, 16'h0001};
        rd(14'h211, 16'h0001);
        rd(14'h212, 16'h0002);
        rd(14'h213, 16'h0003);
        wr(14'h211, 16'hFFFF);
        rd(14'h211, 16'h0001);
        wr(14'h3F0, 16'h1234);
        rd(14'h3F0, 16'h0000);
        rd(14'h209, 16'h0000);
        rd(14'h214, 16'h0000);
        wr(14'h220, 16'hBEEF);
        rd(14'h220, 16'h0080);

        // Same-cycle write and read of one address returns the old value.
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; addr = 14'h202; write_data = 16'h5555;
        exp_q.push_back(16'h0000);
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        rd(14'h202, 16'h5555);

        // Reset during RUN: back to IDLE, later engine_done ignored.
        wr(14'h200, 16'h0001);
        check("pre_rst_pulse", {31'b0, start_pulse}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_pulse", {31'b0, start_pulse}, 0);
        check("rst_run_cfg0", {16'b0, cfg_active[15:0]}, 0);
        pulse_done();
        rd(14'h210, 16'h0000);
        check("rst_run_irq", {31'b0, irq}, 0);
        rd(14'h201, 16'h0000);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
